next_pc_unit: RTL and testbench

- Parametrised successor to the fetch-stage PC select logic: owns the architectural fetch PC register.
- Each cycle, picks the next PC from these sources, in priority order: mispredict recovery, stall hold, deferred redirect, jump, predicted-taken branch slots, branch-handler redirect, sequential increment.
- Adds redirect deferral across stalls, a post-mispredict fetch bubble counter, and N prediction slots.
- Sits between the branch predictor/branch handler/decode-jump logic and the I-cache address port.

---
 rtl/next_pc_unit.sv | 152 +++++++++++++++
 tb/tb_next_pc_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// Fetch PC register and next-PC select: mispredict recovery, stall hold with
// redirect deferral, jump, prediction slots, branch-handler redirect, sequential.
module next_pc_unit #(
    parameter int          PC_W         = 16,
    parameter int          FETCH_W      = 4,
    parameter int          PRED_SLOTS   = 2,
    parameter int          MISP_BUBBLES = 2,
    parameter logic [63:0] RESET_PC     = 64'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_fetch,
    input  logic                       stall_for_jump,
    input  logic                       brch_full,
    input  logic                       has_mispredict,
    input  logic [PC_W-1:0]            recover_pc,
    input  logic                       jump_for_pcsel,
    input  logic [PC_W-1:0]            jump_target,
    input  logic [PRED_SLOTS-1:0]      pred_taken,
    input  logic [PRED_SLOTS*PC_W-1:0] pred_target,
    input  logic                       pcsel_from_bhndlr,
    input  logic [PC_W-1:0]            bhndlr_pc,
    output logic [PC_W-1:0]            pc,
    output logic [2:0]                 pc_src,
    output logic [2:0]                 pred_slot,
    output logic                       fetch_valid
);

    localparam logic [2:0] SRC_PRED     = 3'd0;
    localparam logic [2:0] SRC_PRED_ALT = 3'd1;
    localparam logic [2:0] SRC_JUMP     = 3'd2;
    localparam logic [2:0] SRC_RECOVER  = 3'd3;
    localparam logic [2:0] SRC_BHNDLR   = 3'd4;
    localparam logic [2:0] SRC_SEQ      = 3'd5;
    localparam logic [2:0] SRC_HOLD     = 3'd6;
    localparam logic [2:0] SRC_RESET    = 3'd7;

    localparam logic [3:0]      BUB_INIT = 4'(MISP_BUBBLES);
    localparam logic [PC_W-1:0] PC_INIT  = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_STEP  = PC_W'(FETCH_W);

    // Registered state
    logic [PC_W-1:0] pc_q, pc_n;
    logic [2:0]      src_q, src_n;
    logic [2:0]      slot_q, slot_n;
    logic            valid_q, valid_n;
    logic            pend_valid_q, pend_valid_n;
    logic [PC_W-1:0] pend_tgt_q, pend_tgt_n;
    logic [2:0]      pend_src_q, pend_src_n;
    logic [3:0]      bub_q, bub_n;

    logic            stall;
    logic            pred_hit;
    logic [2:0]      pred_idx;
    logic [PC_W-1:0] pred_tgt;

    assign stall = stall_fetch | stall_for_jump | brch_full | (bub_q != 4'd0);

    // Lowest-numbered (oldest) taken slot wins, so scan from the top down.
    always_comb begin
        pred_hit = 1'b0;
        pred_idx = 3'd0;
        pred_tgt = '0;
        for (int i = PRED_SLOTS - 1; i >= 0; i--) begin
            if (pred_taken[i]) begin
                pred_hit = 1'b1;
                pred_idx = 3'(i);
                pred_tgt = pred_target[i*PC_W +: PC_W];
            end
        end
    end

    always_comb begin
        pc_n         = pc_q;
        src_n        = src_q;
        slot_n       = 3'd0;
        valid_n      = 1'b1;
        pend_valid_n = pend_valid_q;
        pend_tgt_n   = pend_tgt_q;
        pend_src_n   = pend_src_q;
        bub_n        = bub_q;

        if (has_mispredict) begin
            pc_n         = recover_pc;
            src_n        = SRC_RECOVER;
            pend_valid_n = 1'b0;
            bub_n        = BUB_INIT;
            valid_n      = (MISP_BUBBLES == 0);
        end else if (stall) begin
            src_n   = SRC_HOLD;
            valid_n = 1'b0;
            if (bub_q != 4'd0) begin
                bub_n = bub_q - 4'd1;
            end
            // Single-entry deferral; newest request replaces any older one.
            if (jump_for_pcsel) begin
                pend_valid_n = 1'b1;
                pend_tgt_n   = jump_target;
                pend_src_n   = SRC_JUMP;
            end else if (pcsel_from_bhndlr) begin
                pend_valid_n = 1'b1;
                pend_tgt_n   = bhndlr_pc;
                pend_src_n   = SRC_BHNDLR;
            end
        end else if (pend_valid_q) begin
            pc_n         = pend_tgt_q;
            src_n        = pend_src_q;
            pend_valid_n = 1'b0;
        end else if (jump_for_pcsel) begin
            pc_n  = jump_target;
            src_n = SRC_JUMP;
        end else if (pred_hit) begin
            pc_n   = pred_tgt;
            slot_n = pred_idx;
            src_n  = (pred_idx == 3'd0) ? SRC_PRED : SRC_PRED_ALT;
        end else if (pcsel_from_bhndlr) begin
            pc_n  = bhndlr_pc;
            src_n = SRC_BHNDLR;
        end else begin
            pc_n  = pc_q + PC_STEP;
            src_n = SRC_SEQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= PC_INIT;
            src_q        <= SRC_RESET;
            slot_q       <= 3'd0;
            valid_q      <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= '0;
            pend_src_q   <= 3'd0;
            bub_q        <= 4'd0;
        end else begin
            pc_q         <= pc_n;
            src_q        <= src_n;
            slot_q       <= slot_n;
            valid_q      <= valid_n;
            pend_valid_q <= pend_valid_n;
            pend_tgt_q   <= pend_tgt_n;
            pend_src_q   <= pend_src_n;
            bub_q        <= bub_n;
        end
    end

    assign pc          = pc_q;
    assign pc_src      = src_q;
    assign pred_slot   = slot_q;
    assign fetch_valid = valid_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed table-driven bench for next_pc_unit with hand-computed expectations,
// plus short hand-written sequences for bubble, reload and reset corner cases.
module tb_next_pc_unit;

    localparam int PC_W  = 16;
    localparam int SLOTS = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall_fetch, stall_for_jump, brch_full;
    logic              has_mispredict;
    logic [PC_W-1:0]   recover_pc;
    logic              jump_for_pcsel;
    logic [PC_W-1:0]   jump_target;
    logic [SLOTS-1:0]  pred_taken;
    logic [SLOTS*PC_W-1:0] pred_target;
    logic              pcsel_from_bhndlr;
    logic [PC_W-1:0]   bhndlr_pc;
    logic [PC_W-1:0]   pc;
    logic [2:0]        pc_src;
    logic [2:0]        pred_slot;
    logic              fetch_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    next_pc_unit #(
        .PC_W(16), .FETCH_W(4), .PRED_SLOTS(2), .MISP_BUBBLES(2), .RESET_PC(64'd0)
    ) dut (
        .clk(clk), .rst(rst),
        .stall_fetch(stall_fetch), .stall_for_jump(stall_for_jump), .brch_full(brch_full),
        .has_mispredict(has_mispredict), .recover_pc(recover_pc),
        .jump_for_pcsel(jump_for_pcsel), .jump_target(jump_target),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .pcsel_from_bhndlr(pcsel_from_bhndlr), .bhndlr_pc(bhndlr_pc),
        .pc(pc), .pc_src(pc_src), .pred_slot(pred_slot), .fetch_valid(fetch_valid)
    );

    typedef struct {
        logic              rst, sf, sj, bf, misp;
        logic [PC_W-1:0]   rpc;
        logic              jmp;
        logic [PC_W-1:0]   jt;
        logic [SLOTS-1:0]  pt;
        logic [SLOTS*PC_W-1:0] ptgt;
        logic              bh;
        logic [PC_W-1:0]   bpc;
        logic [PC_W-1:0]   e_pc;
        logic [2:0]        e_src;
        logic [2:0]        e_slot;
        logic              e_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic sf, input logic sj, input logic bf,
                       input logic m, input logic [PC_W-1:0] rpc,
                       input logic j, input logic [PC_W-1:0] jt,
                       input logic [SLOTS-1:0] pt, input logic [SLOTS*PC_W-1:0] ptgt,
                       input logic b, input logic [PC_W-1:0] bpc,
                       input logic [PC_W-1:0] e_pc, input logic [2:0] e_src,
                       input logic [2:0] e_slot, input logic e_valid);
        vec_t v;
        v.rst = r; v.sf = sf; v.sj = sj; v.bf = bf; v.misp = m; v.rpc = rpc;
        v.jmp = j; v.jt = jt; v.pt = pt; v.ptgt = ptgt; v.bh = b; v.bpc = bpc;
        v.e_pc = e_pc; v.e_src = e_src; v.e_slot = e_slot; v.e_valid = e_valid;
        vecs.push_back(v);
    endtask

    task automatic idle();
        rst = 1'b0; stall_fetch = 1'b0; stall_for_jump = 1'b0; brch_full = 1'b0;
        has_mispredict = 1'b0; recover_pc = '0; jump_for_pcsel = 1'b0; jump_target = '0;
        pred_taken = '0; pred_target = '0; pcsel_from_bhndlr = 1'b0; bhndlr_pc = '0;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock with current inputs, then check all outputs.
    task automatic step_check(input string name, input logic [PC_W-1:0] e_pc,
                              input logic [2:0] e_src, input logic [2:0] e_slot,
                              input logic e_valid);
        @(posedge clk);
        #1;
        cmp({name, ".pc"}, 32'(pc), 32'(e_pc));
        cmp({name, ".pc_src"}, 32'(pc_src), 32'(e_src));
        cmp({name, ".pred_slot"}, 32'(pred_slot), 32'(e_slot));
        cmp({name, ".fetch_valid"}, 32'(fetch_valid), 32'(e_valid));
    endtask

    initial begin
        idle();
        //   rst sf sj bf misp rpc      jmp jt        pt     ptgt                       bh bpc       e_pc     src  slot v
        add(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0000, 3'd7, 3'd0, 0);
        add(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0000, 3'd7, 3'd0, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0004, 3'd5, 3'd0, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0008, 3'd5, 3'd0, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h000C, 3'd5, 3'd0, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0010, 3'd5, 3'd0, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 1, 16'hFFFC, 2'b00, 32'h0,                     0, 16'h0000, 16'hFFFC, 3'd2, 3'd0, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0000, 3'd5, 3'd0, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b11, {16'h0200, 16'h0100},      0, 16'h0000, 16'h0100, 3'd0, 3'd0, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b10, {16'h0200, 16'h0100},      0, 16'h0000, 16'h0200, 3'd1, 3'd1, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     1, 16'h0300, 16'h0300, 3'd4, 3'd0, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0500, 2'b01, {16'h0000, 16'h0600},      0, 16'h0000, 16'h0500, 3'd2, 3'd0, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b01, {16'h0000, 16'h0600},      1, 16'h0700, 16'h0600, 3'd0, 3'd0, 1);
        // stall with a one-cycle jump in the middle: deferred and released afterwards
        add(0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0600, 3'd6, 3'd0, 0);
        add(0, 1, 0, 0, 0, 16'h0000, 1, 16'h0440, 2'b00, 32'h0,                     0, 16'h0000, 16'h0600, 3'd6, 3'd0, 0);
        add(0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0600, 3'd6, 3'd0, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0999, 2'b00, 32'h0,                     0, 16'h0000, 16'h0440, 3'd2, 3'd0, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0444, 3'd5, 3'd0, 1);
        // mispredict overrides brch_full, then two bubble cycles
        add(0, 0, 0, 1, 1, 16'h0080, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0080, 3'd3, 3'd0, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0080, 3'd6, 3'd0, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0080, 3'd6, 3'd0, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0084, 3'd5, 3'd0, 1);
        // pending bhndlr discarded by a mispredict
        add(0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     1, 16'h0300, 16'h0084, 3'd6, 3'd0, 0);
        add(0, 0, 0, 0, 1, 16'h0010, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0010, 3'd3, 3'd0, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0010, 3'd6, 3'd0, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0010, 3'd6, 3'd0, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0014, 3'd5, 3'd0, 1);
        // jump beats bhndlr when latched; a later bhndlr overwrites the entry
        add(0, 0, 0, 1, 0, 16'h0000, 1, 16'h0A00, 2'b00, 32'h0,                     1, 16'h0B00, 16'h0014, 3'd6, 3'd0, 0);
        add(0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     1, 16'h0C00, 16'h0014, 3'd6, 3'd0, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 32'h0,                     0, 16'h0000, 16'h0C00, 3'd4, 3'd0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; stall_fetch = vecs[i].sf; stall_for_jump = vecs[i].sj;
            brch_full = vecs[i].bf; has_mispredict = vecs[i].misp; recover_pc = vecs[i].rpc;
            jump_for_pcsel = vecs[i].jmp; jump_target = vecs[i].jt;
            pred_taken = vecs[i].pt; pred_target = vecs[i].ptgt;
            pcsel_from_bhndlr = vecs[i].bh; bhndlr_pc = vecs[i].bpc;
            step_check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_src,
                       vecs[i].e_slot, vecs[i].e_valid);
        end

        // Mispredict during a bubble reloads the counter.
        idle(); has_mispredict = 1'b1; recover_pc = 16'h0100;
        step_check("reload.rec1", 16'h0100, 3'd3, 3'd0, 0);
        idle();
        step_check("reload.hold1", 16'h0100, 3'd6, 3'd0, 0);
        has_mispredict = 1'b1; recover_pc = 16'h0200;
        step_check("reload.rec2", 16'h0200, 3'd3, 3'd0, 0);
        idle();
        step_check("reload.hold2", 16'h0200, 3'd6, 3'd0, 0);
        step_check("reload.hold3", 16'h0200, 3'd6, 3'd0, 0);
        step_check("reload.seq", 16'h0204, 3'd5, 3'd0, 1);

        // External stall overlapping the bubble keeps holding past it.
        has_mispredict = 1'b1; recover_pc = 16'h0040;
        step_check("ovl.rec", 16'h0040, 3'd3, 3'd0, 0);
        idle(); stall_fetch = 1'b1;
        step_check("ovl.hold1", 16'h0040, 3'd6, 3'd0, 0);
        step_check("ovl.hold2", 16'h0040, 3'd6, 3'd0, 0);
        step_check("ovl.hold3", 16'h0040, 3'd6, 3'd0, 0);
        idle();
        step_check("ovl.seq", 16'h0044, 3'd5, 3'd0, 1);

        // Reset mid-bubble with a redirect pending clears both.
        has_mispredict = 1'b1; recover_pc = 16'h0100;
        step_check("rstmid.rec", 16'h0100, 3'd3, 3'd0, 0);
        idle(); jump_for_pcsel = 1'b1; jump_target = 16'h0ABC;
        step_check("rstmid.pend", 16'h0100, 3'd6, 3'd0, 0);
        idle(); rst = 1'b1;
        step_check("rstmid.rst", 16'h0000, 3'd7, 3'd0, 0);
        idle();
        step_check("rstmid.seq", 16'h0004, 3'd5, 3'd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
